// File: rtl/rl_force_cache.sv
// rl_force_cache: per-cell force accumulation cache.
// Receives (particle_id, Fx, Fy, Fz) partial forces and accumulates each one
// into a per-particle slot with a pipelined read-modify-write through three
// FP adders. On request it streams the totals out and zeroes each slot it reads.
// Optional build macro RL_FORCE_CACHE_STATS_EN adds accept/drop/stall counters.

// Single-precision adder: one combinational add, then a register chain so the
// result appears LATENCY cycles after the operands. Denormals are flushed to
// zero and rounding is round-to-nearest-even.
module rl_fp_add #(
   parameter int LATENCY = 3
) (
   input  logic        clk,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);

   function automatic logic [31:0] fp_add(input logic [31:0] p, input logic [31:0] q);
      logic [31:0] x, y;
      logic [26:0] mx, my, ys;
      logic [27:0] s;
      logic [24:0] m25;
      logic        sgn, sticky, rnd;
      int          sh, e;
      // Inf/NaN operands pass straight through
      if (p[30:23] == 8'hFF) return p;
      if (q[30:23] == 8'hFF) return q;
      // x is the operand with the larger magnitude
      if (p[30:0] < q[30:0]) begin
         x = q;
         y = p;
      end else begin
         x = p;
         y = q;
      end
      if (x[30:23] == 8'h00) return 32'h0;
      if (y[30:23] == 8'h00) return x;
      // 1 hidden + 23 fraction + guard/round/sticky
      mx = {1'b1, x[22:0], 3'b000};
      my = {1'b1, y[22:0], 3'b000};
      sh = int'(x[30:23]) - int'(y[30:23]);
      if (sh > 26) begin
         ys = 27'd1;
      end else begin
         ys     = my >> sh;
         sticky = |(my & ((27'd1 << sh) - 27'd1));
         ys[0]  = ys[0] | sticky;
      end
      e   = int'(x[30:23]);
      sgn = x[31];
      if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, ys};
      else                s = {1'b0, mx} - {1'b0, ys};
      if (s == 28'd0) return 32'h0;
      if (s[27]) begin
         s = {1'b0, s[27:2], s[1] | s[0]};
         e = e + 1;
      end else begin
         for (int i = 0; i < 26; i++) begin
            if (!s[26]) begin
               s = s << 1;
               e = e - 1;
            end
         end
      end
      rnd = s[2] & (s[1] | s[0] | s[3]);
      m25 = {1'b0, s[26:3]} + {24'b0, rnd};
      if (m25[24]) begin
         m25 = m25 >> 1;
         e   = e + 1;
      end
      if (e >= 255) return {sgn, 8'hFF, 23'b0};
      if (e <= 0)   return {sgn, 31'b0};
      return {sgn, e[7:0], m25[22:0]};
   endfunction

   logic [31:0] pipe [LATENCY];

   // Result delay chain
   always_ff @(posedge clk) begin
      pipe[0] <= fp_add(a, b);
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
   end

   assign sum = pipe[LATENCY-1];

endmodule

module rl_force_cache #(
   parameter int DATA_WIDTH            = 32,
   parameter int CELL_ID_WIDTH         = 4,
   parameter int CELL_ADDR_WIDTH       = 8,
   parameter int PARTICLE_ID_WIDTH     = CELL_ID_WIDTH*3+CELL_ADDR_WIDTH,
   parameter int MAX_CELL_PARTICLE_NUM = 220,
   parameter int CELL_X                = 2,
   parameter int CELL_Y                = 2,
   parameter int CELL_Z                = 2,
   parameter int ADDER_LATENCY         = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_partial_force_valid,
   input  logic [PARTICLE_ID_WIDTH-1:0] in_particle_id,
   input  logic [DATA_WIDTH-1:0]        in_partial_force_x,
   input  logic [DATA_WIDTH-1:0]        in_partial_force_y,
   input  logic [DATA_WIDTH-1:0]        in_partial_force_z,
   output logic                         out_back_pressure,
   input  logic                         in_readout_start,
   input  logic [CELL_ADDR_WIDTH-1:0]   in_readout_num,
   output logic [PARTICLE_ID_WIDTH-1:0] out_particle_id,
   output logic [DATA_WIDTH-1:0]        out_force_x,
   output logic [DATA_WIDTH-1:0]        out_force_y,
   output logic [DATA_WIDTH-1:0]        out_force_z,
   output logic                         out_force_valid,
`ifdef RL_FORCE_CACHE_STATS_EN
   output logic [31:0]                  out_accept_count,
   output logic [31:0]                  out_drop_count,
   output logic [31:0]                  out_stall_count,
`endif
   output logic                         out_readout_done
);

   localparam int CAW = CELL_ADDR_WIDTH;
   localparam int CIW = CELL_ID_WIDTH;
   localparam int DW  = DATA_WIDTH;
   localparam int FW  = 3*DATA_WIDTH;
   // Pipe index 0 = read data returned, 1..ADDER_LATENCY = adder, last = write
   localparam int STAGES = ADDER_LATENCY + 1;
   localparam logic [3*CIW-1:0] MY_CELL   = {CIW'(CELL_X), CIW'(CELL_Y), CIW'(CELL_Z)};
   localparam logic [CAW:0]     MAX_W     = (CAW+1)'(MAX_CELL_PARTICLE_NUM);
   localparam logic [CAW-1:0]   LAST_SLOT = CAW'(MAX_CELL_PARTICLE_NUM-1);

   typedef enum logic [1:0] {INIT, ACCUM, DRAIN_WAIT, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [FW-1:0]    mem [MAX_CELL_PARTICLE_NUM];
   logic [CAW-1:0]   in_addr;
   logic             in_local, hit, accept, accept_local, pipe_busy, drain_rd;
   logic [STAGES:0]  vld_pipe;
   logic [CAW-1:0]   addr_pipe [STAGES+1];
   logic [FW-1:0]    rd_q, f_q, add_out, wr_q;
   logic [CAW-1:0]   init_cnt, drain_cnt, drain_num;

   assign in_addr  = in_particle_id[CAW-1:0];
   // Inputs for other cells or beyond the slot range are swallowed silently
   assign in_local = (in_particle_id[PARTICLE_ID_WIDTH-1:CAW] == MY_CELL) &&
                     ({1'b0, in_addr} < MAX_W);

   // Address hazard against every op still between read and write-back
   always_comb begin
      hit = 1'b0;
      for (int k = 0; k <= STAGES; k++)
         if (vld_pipe[k] && addr_pipe[k] == in_addr) hit = 1'b1;
   end

   assign out_back_pressure = (state_q != ACCUM) ||
                              (in_partial_force_valid && in_local && hit);
   assign accept       = in_partial_force_valid && !out_back_pressure;
   assign accept_local = accept && in_local;
   assign pipe_busy    = |vld_pipe;
   assign drain_rd     = (state_q == DRAIN) && (drain_cnt != drain_num);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= INIT;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:       if (init_cnt == LAST_SLOT) state_d = ACCUM;
         ACCUM:      if (in_readout_start) state_d = DRAIN_WAIT;
         DRAIN_WAIT: if (!pipe_busy) state_d = DRAIN;
         DRAIN:      if (drain_cnt == drain_num) state_d = ACCUM;
         default:    state_d = INIT;
      endcase
   end

   // Init sweep and drain address counters
   always_ff @(posedge clk) begin
      if (rst) begin
         init_cnt  <= '0;
         drain_cnt <= '0;
         drain_num <= '0;
      end else begin
         if (state_q == INIT) init_cnt <= init_cnt + 1'b1;
         if (state_q == ACCUM && in_readout_start) begin
            drain_cnt <= '0;
            drain_num <= ({1'b0, in_readout_num} > MAX_W) ? MAX_W[CAW-1:0] : in_readout_num;
         end else if (drain_rd) begin
            drain_cnt <= drain_cnt + 1'b1;
         end
      end
   end

   // Valid shift register; cleared on reset so in-flight sums are dropped
   always_ff @(posedge clk) begin
      if (rst) vld_pipe <= '0;
      else     vld_pipe <= {vld_pipe[STAGES-1:0], accept_local};
   end

   // Address and operand pipeline
   always_ff @(posedge clk) begin
      addr_pipe[0] <= in_addr;
      for (int k = 1; k <= STAGES; k++) addr_pipe[k] <= addr_pipe[k-1];
      f_q  <= {in_partial_force_z, in_partial_force_y, in_partial_force_x};
      wr_q <= add_out;
   end

   // One adder per axis; operands arrive one cycle after the accept
   for (genvar g = 0; g < 3; g++) begin : g_axis
      rl_fp_add #(.LATENCY(ADDER_LATENCY)) u_add (
         .clk (clk),
         .a   (rd_q[g*DW +: DW]),
         .b   (f_q[g*DW +: DW]),
         .sum (add_out[g*DW +: DW])
      );
   end

   // Slot memory: init zeroing, drain zeroing, or accumulation write-back
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == INIT)         mem[init_cnt] <= '0;
         else if (drain_rd)           mem[drain_cnt] <= '0;
         else if (vld_pipe[STAGES])   mem[addr_pipe[STAGES]] <= wr_q;
      end
      if (accept_local) rd_q <= mem[in_addr];
   end

   // Readout stream: one slot per cycle, done pulse after the last one
   always_ff @(posedge clk) begin
      if (rst) begin
         out_particle_id  <= '0;
         out_force_x      <= '0;
         out_force_y      <= '0;
         out_force_z      <= '0;
         out_force_valid  <= 1'b0;
         out_readout_done <= 1'b0;
      end else begin
         out_force_valid  <= 1'b0;
         out_readout_done <= 1'b0;
         if (drain_rd) begin
            out_force_valid <= 1'b1;
            out_particle_id <= {MY_CELL, drain_cnt};
            out_force_x     <= mem[drain_cnt][0*DW +: DW];
            out_force_y     <= mem[drain_cnt][1*DW +: DW];
            out_force_z     <= mem[drain_cnt][2*DW +: DW];
         end else if (state_q == DRAIN) begin
            out_readout_done <= 1'b1;
         end
      end
   end

`ifdef RL_FORCE_CACHE_STATS_EN
   // Saturating traffic counters
   always_ff @(posedge clk) begin
      if (rst) begin
         out_accept_count <= '0;
         out_drop_count   <= '0;
         out_stall_count  <= '0;
      end else begin
         if (accept_local && out_accept_count != 32'hFFFF_FFFF)
            out_accept_count <= out_accept_count + 32'd1;
         if (accept && !in_local && out_drop_count != 32'hFFFF_FFFF)
            out_drop_count <= out_drop_count + 32'd1;
         if (state_q == ACCUM && in_partial_force_valid && out_back_pressure &&
             out_stall_count != 32'hFFFF_FFFF)
            out_stall_count <= out_stall_count + 32'd1;
      end
   end
`else
   // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_rl_force_cache.sv
// Directed bench for rl_force_cache (default parameters, cell 2,2,2, 220 slots).
module tb_rl_force_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_partial_force_valid;
   logic [19:0] in_particle_id;
   logic [31:0] in_partial_force_x, in_partial_force_y, in_partial_force_z;
   logic        out_back_pressure;
   logic        in_readout_start;
   logic [7:0]  in_readout_num;
   logic [19:0] out_particle_id;
   logic [31:0] out_force_x, out_force_y, out_force_z;
   logic        out_force_valid, out_readout_done;
`ifdef RL_FORCE_CACHE_STATS_EN
   logic [31:0] out_accept_count, out_drop_count, out_stall_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] dfx [256];
   logic [31:0] dfy [256];
   logic [31:0] dfz [256];
   logic [19:0] did [256];
   int          dn, dwait;
   bit          ddone;

   rl_force_cache dut (
      .clk                    (clk),
      .rst                    (rst),
      .in_partial_force_valid (in_partial_force_valid),
      .in_particle_id         (in_particle_id),
      .in_partial_force_x     (in_partial_force_x),
      .in_partial_force_y     (in_partial_force_y),
      .in_partial_force_z     (in_partial_force_z),
      .out_back_pressure      (out_back_pressure),
      .in_readout_start       (in_readout_start),
      .in_readout_num         (in_readout_num),
      .out_particle_id        (out_particle_id),
      .out_force_x            (out_force_x),
      .out_force_y            (out_force_y),
      .out_force_z            (out_force_z),
      .out_force_valid        (out_force_valid),
`ifdef RL_FORCE_CACHE_STATS_EN
      .out_accept_count       (out_accept_count),
      .out_drop_count         (out_drop_count),
      .out_stall_count        (out_stall_count),
`endif
      .out_readout_done       (out_readout_done)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] mk_id(input int cx, input int cy, input int cz, input int a);
      return {4'(cx), 4'(cy), 4'(cz), 8'(a)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one partial force, hold it through back pressure, count stall cycles
   task automatic send(input logic [19:0] id, input logic [31:0] fx, input logic [31:0] fy,
                       input logic [31:0] fz, output int stalls);
      bit ok;
      ok = 0;
      stalls = 0;
      in_partial_force_valid = 1'b1;
      in_particle_id = id;
      in_partial_force_x = fx;
      in_partial_force_y = fy;
      in_partial_force_z = fz;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!out_back_pressure) begin
            ok = 1;
            break;
         end
         stalls++;
         step();
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL send_timeout id %h still back-pressured after %0d cycles", id, stalls);
      end
      step();
      in_partial_force_valid = 1'b0;
   endtask

   // Gather a readout stream until the done pulse (bounded)
   task automatic collect();
      dn = 0; dwait = 0; ddone = 0;
      for (int i = 0; i < 600 && !ddone; i++) begin
         @(negedge clk);
         if (out_force_valid) begin
            if (dn < 256) begin
               dfx[dn] = out_force_x; dfy[dn] = out_force_y;
               dfz[dn] = out_force_z; did[dn] = out_particle_id;
            end
            dn++;
         end else if (dn == 0) begin
            dwait++;
         end
         if (out_readout_done) ddone = 1;
      end
      if (!ddone) begin
         checks++; errors++;
         $display("FAIL drain_timeout got %0d valids and no done pulse", dn);
      end
      step();
   endtask

   task automatic do_drain(input int num);
      in_readout_num = 8'(num);
      in_readout_start = 1'b1;
      step();
      in_readout_start = 1'b0;
      collect();
   endtask

   // Count cycles of back pressure after reset release (bounded)
   task automatic wait_init(output int bp_cycles);
      bp_cycles = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!out_back_pressure) break;
         bp_cycles++;
         step();
      end
      step();
   endtask

   task automatic test_reset();
      int bpc, bad;
      rst = 1'b1;
      repeat (3) step();
      @(negedge clk);
      checks++;
      if (out_back_pressure !== 1'b1 || out_force_valid !== 1'b0 || out_readout_done !== 1'b0 ||
          out_particle_id !== 20'h0 || out_force_x !== 32'h0 || out_force_y !== 32'h0 ||
          out_force_z !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs got bp=%b v=%b d=%b id=%h fx=%h want bp=1 others 0",
                  out_back_pressure, out_force_valid, out_readout_done, out_particle_id, out_force_x);
      end
      step();
      rst = 1'b0;
      in_readout_num = 8'd5;
      in_readout_start = 1'b1;   // outside ACCUM: must be ignored
      step();
      in_readout_start = 1'b0;
      wait_init(bpc);
      bpc = bpc + 1;             // first INIT cycle was consumed by the ignored start pulse
      checks++;
      if (bpc !== 220) begin
         errors++;
         $display("FAIL init_bp_cycles got %0d want 220", bpc);
      end
      do_drain(220);
      checks++;
      if (dn !== 220) begin
         errors++;
         $display("FAIL init_drain_count got %0d want 220", dn);
      end
      bad = 0;
      for (int i = 0; i < 220; i++)
         if (dfx[i] !== 32'h0 || dfy[i] !== 32'h0 || dfz[i] !== 32'h0) bad++;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL init_drain_zero got %0d nonzero slots want 0", bad);
      end
      bad = 0;
      for (int i = 0; i < 220; i++) if (did[i] !== mk_id(2, 2, 2, i)) bad++;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL init_drain_ids got %0d wrong ids want 0", bad);
      end
   endtask

   task automatic test_accum_hazard();
      int s0, s1;
      send(mk_id(2, 2, 2, 5), 32'h3F800000, 32'h0, 32'h0, s0);
      send(mk_id(2, 2, 2, 5), 32'h40000000, 32'h0, 32'h0, s1);
      checks++;
      if (s0 !== 0 || s1 !== 5) begin
         errors++;
         $display("FAIL hazard_stalls got %0d/%0d want 0/5", s0, s1);
      end
      do_drain(6);
      checks++;
      if (dn !== 6 || dfx[5] !== 32'h40400000 || dfy[5] !== 32'h0 || did[5] !== mk_id(2, 2, 2, 5)) begin
         errors++;
         $display("FAIL hazard_sum got n=%0d fx=%h id=%h want n=6 fx=40400000 id=%h",
                  dn, dfx[5], did[5], mk_id(2, 2, 2, 5));
      end
      do_drain(6);
      checks++;
      if (dfx[5] !== 32'h0) begin
         errors++;
         $display("FAIL hazard_cleared got %h want 00000000", dfx[5]);
      end
   endtask

   task automatic test_distinct();
      int s, tot, bad;
      tot = 0;
      for (int a = 0; a < 10; a++) begin
         send(mk_id(2, 2, 2, a), 32'h0, 32'h3F800000, 32'h0, s);
         tot += s;
      end
      checks++;
      if (tot !== 0) begin
         errors++;
         $display("FAIL distinct_stalls got %0d want 0", tot);
      end
      do_drain(10);
      bad = 0;
      for (int a = 0; a < 10; a++)
         if (dfy[a] !== 32'h3F800000 || dfx[a] !== 32'h0 || dfz[a] !== 32'h0) bad++;
      checks++;
      if (dn !== 10 || bad !== 0) begin
         errors++;
         $display("FAIL distinct_drain got n=%0d bad=%0d want n=10 bad=0", dn, bad);
      end
   endtask

   task automatic test_drop();
      int s0, s1, s2, bad;
      send(mk_id(2, 2, 2, 3), 32'h0, 32'h0, 32'h3F800000, s0);
      send(mk_id(3, 2, 2, 3), 32'h3F800000, 32'h0, 32'h0, s1);
      send(mk_id(2, 2, 2, 230), 32'h3F800000, 32'h0, 32'h0, s2);
      checks++;
      if (s1 !== 0 || s2 !== 0) begin
         errors++;
         $display("FAIL drop_stalls got %0d/%0d want 0/0", s1, s2);
      end
`ifdef RL_FORCE_CACHE_STATS_EN
      repeat (2) step();
      checks++;
      if (out_drop_count !== 32'd2 || out_accept_count !== 32'd13 || out_stall_count !== 32'd5) begin
         errors++;
         $display("FAIL stats got drop=%0d acc=%0d stall=%0d want 2/13/5",
                  out_drop_count, out_accept_count, out_stall_count);
      end
`endif
      do_drain(10);
      bad = 0;
      for (int a = 0; a < 10; a++)
         if (dfx[a] !== 32'h0 || dfy[a] !== 32'h0 || dfz[a] !== ((a == 3) ? 32'h3F800000 : 32'h0)) bad++;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL drop_slots got %0d changed slots want 0", bad);
      end
   endtask

   task automatic test_partial_drain();
      int s;
      send(mk_id(2, 2, 2, 3), 32'h3F800000, 32'h0, 32'h0, s);
      send(mk_id(2, 2, 2, 3), 32'hBF000000, 32'h0, 32'h0, s);
      do_drain(2);
      checks++;
      if (dn !== 2) begin
         errors++;
         $display("FAIL partial_count got %0d want 2", dn);
      end
      do_drain(4);
      checks++;
      if (dfx[3] !== 32'h3F000000 || dfx[0] !== 32'h0) begin
         errors++;
         $display("FAIL partial_keep got %h want 3F000000", dfx[3]);
      end
   endtask

   task automatic test_drain_inflight();
      int s;
      send(mk_id(2, 2, 2, 0), 32'h3F800000, 32'h0, 32'h0, s);
      send(mk_id(2, 2, 2, 1), 32'h40000000, 32'h0, 32'h0, s);
      in_readout_num = 8'd3;
      in_readout_start = 1'b1;   // same cycle as the third input
      send(mk_id(2, 2, 2, 2), 32'h40400000, 32'h0, 32'h0, s);
      in_readout_start = 1'b0;
      collect();
      checks++;
      if (dwait !== 7) begin
         errors++;
         $display("FAIL inflight_wait got %0d idle cycles want 7", dwait);
      end
      checks++;
      if (dn !== 3 || dfx[0] !== 32'h3F800000 || dfx[1] !== 32'h40000000 || dfx[2] !== 32'h40400000) begin
         errors++;
         $display("FAIL inflight_totals got n=%0d %h %h %h want 3 3F800000 40000000 40400000",
                  dn, dfx[0], dfx[1], dfx[2]);
      end
   endtask

   task automatic test_readout_zero();
      do_drain(0);
      checks++;
      if (dn !== 0 || ddone !== 1'b1) begin
         errors++;
         $display("FAIL zero_drain got n=%0d done=%b want 0/1", dn, ddone);
      end
      @(negedge clk);
      checks++;
      if (out_back_pressure !== 1'b0) begin
         errors++;
         $display("FAIL zero_back_to_accum got bp=%b want 0", out_back_pressure);
      end
      step();
   endtask

   task automatic test_reset_mid_drain();
      int s, bpc, bad;
      send(mk_id(2, 2, 2, 4), 32'h3F800000, 32'h0, 32'h0, s);
      in_readout_num = 8'd10;
      in_readout_start = 1'b1;
      step();
      in_readout_start = 1'b0;
      repeat (8) step();
      rst = 1'b1;
      step();
      @(negedge clk);
      checks++;
      if (out_force_valid !== 1'b0 || out_readout_done !== 1'b0 || out_particle_id !== 20'h0 ||
          out_force_x !== 32'h0 || out_back_pressure !== 1'b1) begin
         errors++;
         $display("FAIL midrst_outputs got v=%b d=%b id=%h fx=%h bp=%b want 0 0 0 0 1",
                  out_force_valid, out_readout_done, out_particle_id, out_force_x, out_back_pressure);
      end
      step();
      rst = 1'b0;
      wait_init(bpc);
      checks++;
      if (bpc !== 220) begin
         errors++;
         $display("FAIL midrst_init got %0d want 220", bpc);
      end
      do_drain(10);
      bad = 0;
      for (int a = 0; a < 10; a++) if (dfx[a] !== 32'h0 || dfy[a] !== 32'h0 || dfz[a] !== 32'h0) bad++;
      checks++;
      if (dn !== 10 || bad !== 0) begin
         errors++;
         $display("FAIL midrst_zero got n=%0d nonzero=%0d want 10/0", dn, bad);
      end
   endtask

   initial begin
      rst = 1'b1;
      in_partial_force_valid = 1'b0;
      in_particle_id = '0;
      in_partial_force_x = '0;
      in_partial_force_y = '0;
      in_partial_force_z = '0;
      in_readout_start = 1'b0;
      in_readout_num = '0;
      test_reset();
      test_accum_hazard();
      test_distinct();
      test_drop();
      test_partial_drain();
      test_drain_inflight();
      test_readout_zero();
      test_reset_mid_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
